// File: rtl/bus_uart_if.sv
// Register-bus bundle for bus_uart: zero-wait-state select/read/write access
// with byte strobes, combinational read data and error response.
interface bus_uart_if;
    logic        select;
    logic [3:2]  address;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic [3:0]  data_strobes;
    logic        read;
    logic        write;
    logic        bus_error;

    modport master (
        output select, address, data_in, data_strobes, read, write,
        input  data_out, bus_error
    );

    modport slave (
        input  select, address, data_in, data_strobes, read, write,
        output data_out, bus_error
    );
endinterface

// File: rtl/bus_uart.sv
// Memory-mapped UART: TX FIFO feeding an 8N1 transmitter, single-byte receive
// buffer with overrun/framing flags, programmable bit divisor and interrupt.
module bus_uart #(
    parameter int unsigned FIFO_DEPTH    = 8,
    parameter logic [15:0] DIVISOR_RESET = 16'h0363
) (
    input  logic       i_clock,
    input  logic       i_reset,
    bus_uart_if.slave  io_bus,
    output logic       o_txd,
    input  logic       i_rxd,
    output logic       o_irq
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FullCount = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_t;

    // Registers
    logic [7:0]    r_fifo [FIFO_DEPTH];
    logic [AW-1:0] r_wptr, r_rptr;
    logic [AW:0]   r_count;
    logic [15:0]   r_divisor;
    logic          r_rx_ie, r_tx_ie, r_irq;

    state_t        r_tx_state, w_tx_state_d;
    logic [15:0]   r_tx_cnt, w_tx_cnt_d;
    logic [2:0]    r_tx_bit, w_tx_bit_d;
    logic [7:0]    r_tx_shift, w_tx_shift_d;

    state_t        r_rx_state, w_rx_state_d;
    logic [15:0]   r_rx_cnt, w_rx_cnt_d;
    logic [2:0]    r_rx_bit, w_rx_bit_d;
    logic [7:0]    r_rx_shift, w_rx_shift_d;
    logic          r_rx_sync1, r_rx_sync2, r_rx_prev;
    logic [7:0]    r_rx_byte;
    logic          r_rx_valid, r_rx_overrun, r_rx_frame_err;

    // Decode
    logic w_rd, w_wr, w_data_wr, w_data_rd, w_status_rd;
    logic w_push, w_pop, w_tx_empty, w_tx_full, w_tx_busy, w_rx_done;
    logic w_tx_tick, w_rx_tick, w_rx_fall;
    logic [31:0] w_status, w_rdata;
    logic w_unused;

    assign w_rd        = io_bus.select & io_bus.read;
    assign w_wr        = io_bus.select & io_bus.write;
    assign w_data_wr   = w_wr & (io_bus.address == 2'd0);
    assign w_data_rd   = w_rd & (io_bus.address == 2'd0);
    assign w_status_rd = w_rd & (io_bus.address == 2'd1);

    assign w_tx_empty  = (r_count == '0);
    assign w_tx_full   = (r_count == FullCount);
    assign w_tx_busy   = (r_tx_state != StIdle);
    // Full is judged at the start of the cycle, so a same-cycle pop never frees room.
    assign w_push      = w_data_wr & io_bus.data_strobes[0] & ~w_tx_full;
    assign io_bus.bus_error = w_data_wr & (~io_bus.data_strobes[0] | w_tx_full);

    assign w_status = {26'b0, r_rx_frame_err, w_tx_busy, r_rx_overrun, r_rx_valid,
                       w_tx_full, w_tx_empty};
    assign w_unused = ^io_bus.data_in[31:16];

    always_comb begin
        w_rdata = '0;
        if (w_rd) begin
            case (io_bus.address)
                2'd0: w_rdata = {24'b0, r_rx_byte};
                2'd1: w_rdata = w_status;
                2'd2: w_rdata = {16'b0, r_divisor};
                default: w_rdata = {30'b0, r_tx_ie, r_rx_ie};
            endcase
        end
    end
    assign io_bus.data_out = w_rdata;

    // Transmitter next state; the counter reloads from the live divisor only
    // at bit boundaries.
    assign w_tx_tick = (r_tx_cnt == '0);

    always_comb begin
        w_tx_state_d = r_tx_state;
        w_tx_cnt_d   = r_tx_cnt;
        w_tx_bit_d   = r_tx_bit;
        w_tx_shift_d = r_tx_shift;
        w_pop        = 1'b0;
        if (r_tx_state != StIdle) begin
            w_tx_cnt_d = w_tx_tick ? r_divisor : r_tx_cnt - 16'd1;
        end
        case (r_tx_state)
            StIdle: begin
                if (!w_tx_empty) begin
                    w_pop        = 1'b1;
                    w_tx_shift_d = r_fifo[r_rptr];
                    w_tx_cnt_d   = r_divisor;
                    w_tx_state_d = StStart;
                end
            end
            StStart: begin
                if (w_tx_tick) begin
                    w_tx_bit_d   = 3'd0;
                    w_tx_state_d = StData;
                end
            end
            StData: begin
                if (w_tx_tick) begin
                    w_tx_shift_d = {1'b0, r_tx_shift[7:1]};
                    w_tx_bit_d   = r_tx_bit + 3'd1;
                    if (r_tx_bit == 3'd7) w_tx_state_d = StStop;
                end
            end
            default: begin
                if (w_tx_tick) begin
                    if (!w_tx_empty) begin
                        w_pop        = 1'b1;
                        w_tx_shift_d = r_fifo[r_rptr];
                        w_tx_state_d = StStart;
                    end else begin
                        w_tx_state_d = StIdle;
                    end
                end
            end
        endcase
    end

    always_comb begin
        case (r_tx_state)
            StStart: o_txd = 1'b0;
            StData:  o_txd = r_tx_shift[0];
            default: o_txd = 1'b1;
        endcase
    end

    // Receiver next state
    assign w_rx_tick = (r_rx_cnt == '0);
    assign w_rx_fall = r_rx_prev & ~r_rx_sync2;

    always_comb begin
        w_rx_state_d = r_rx_state;
        w_rx_cnt_d   = r_rx_cnt;
        w_rx_bit_d   = r_rx_bit;
        w_rx_shift_d = r_rx_shift;
        w_rx_done    = 1'b0;
        if (r_rx_state != StIdle) begin
            w_rx_cnt_d = w_rx_tick ? r_divisor : r_rx_cnt - 16'd1;
        end
        case (r_rx_state)
            StIdle: begin
                if (w_rx_fall) begin
                    w_rx_cnt_d   = {1'b0, r_divisor[15:1]};
                    w_rx_state_d = StStart;
                end
            end
            StStart: begin
                if (w_rx_tick) begin
                    w_rx_bit_d   = 3'd0;
                    w_rx_state_d = r_rx_sync2 ? StIdle : StData;
                end
            end
            StData: begin
                if (w_rx_tick) begin
                    w_rx_shift_d = {r_rx_sync2, r_rx_shift[7:1]};
                    w_rx_bit_d   = r_rx_bit + 3'd1;
                    if (r_rx_bit == 3'd7) w_rx_state_d = StStop;
                end
            end
            default: begin
                if (w_rx_tick) begin
                    w_rx_done    = 1'b1;
                    w_rx_state_d = StIdle;
                end
            end
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (w_push) r_fifo[r_wptr] <= io_bus.data_in[7:0];
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_wptr         <= '0;
            r_rptr         <= '0;
            r_count        <= '0;
            r_divisor      <= DIVISOR_RESET;
            r_rx_ie        <= 1'b0;
            r_tx_ie        <= 1'b0;
            r_irq          <= 1'b0;
            r_tx_state     <= StIdle;
            r_tx_cnt       <= '0;
            r_tx_bit       <= '0;
            r_tx_shift     <= '0;
            r_rx_state     <= StIdle;
            r_rx_cnt       <= '0;
            r_rx_bit       <= '0;
            r_rx_shift     <= '0;
            r_rx_sync1     <= 1'b1;
            r_rx_sync2     <= 1'b1;
            r_rx_prev      <= 1'b1;
            r_rx_byte      <= '0;
            r_rx_valid     <= 1'b0;
            r_rx_overrun   <= 1'b0;
            r_rx_frame_err <= 1'b0;
        end else begin
            r_wptr  <= r_wptr + AW'(w_push);
            r_rptr  <= r_rptr + AW'(w_pop);
            r_count <= r_count + (AW + 1)'(w_push) - (AW + 1)'(w_pop);

            if (w_wr && io_bus.address == 2'd2) begin
                if (io_bus.data_strobes[0]) r_divisor[7:0]  <= io_bus.data_in[7:0];
                if (io_bus.data_strobes[1]) r_divisor[15:8] <= io_bus.data_in[15:8];
            end
            if (w_wr && io_bus.address == 2'd3 && io_bus.data_strobes[0]) begin
                r_rx_ie <= io_bus.data_in[0];
                r_tx_ie <= io_bus.data_in[1];
            end
            r_irq <= (r_rx_ie & r_rx_valid) | (r_tx_ie & w_tx_empty);

            r_tx_state <= w_tx_state_d;
            r_tx_cnt   <= w_tx_cnt_d;
            r_tx_bit   <= w_tx_bit_d;
            r_tx_shift <= w_tx_shift_d;

            r_rx_sync1 <= i_rxd;
            r_rx_sync2 <= r_rx_sync1;
            r_rx_prev  <= r_rx_sync2;
            r_rx_state <= w_rx_state_d;
            r_rx_cnt   <= w_rx_cnt_d;
            r_rx_bit   <= w_rx_bit_d;
            r_rx_shift <= w_rx_shift_d;

            // Completion wins over a same-cycle clearing read.
            if (w_rx_done) r_rx_byte <= r_rx_shift;
            r_rx_valid     <= w_rx_done | (r_rx_valid & ~w_data_rd);
            r_rx_overrun   <= (w_rx_done & r_rx_valid & ~w_data_rd) |
                              (r_rx_overrun & ~w_status_rd);
            r_rx_frame_err <= (w_rx_done & ~r_rx_sync2) | (r_rx_frame_err & ~w_status_rd);
        end
    end

    assign o_irq = r_irq;
endmodule

// File: tb/tb_bus_uart.sv
// Directed-plus-random bench for bus_uart: serial frames are predicted from
// byte queues and the 8N1 frame rule, register reads from the register map.
module tb_bus_uart;
    localparam int unsigned Depth = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rxd = 1'b1;
    logic txd, irq;

    bus_uart_if bus ();

    bus_uart #(
        .FIFO_DEPTH   (Depth),
        .DIVISOR_RESET(16'h0363)
    ) dut (
        .i_clock(clk),
        .i_reset(rst_n),
        .io_bus (bus),
        .o_txd  (txd),
        .i_rxd  (rxd),
        .o_irq  (irq)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    logic [7:0] txq[$];
    logic [7:0] rxq[$];

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [9:0] frame_of(input logic [7:0] b, input logic stop_bit);
        return {stop_bit, b, 1'b0};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle_bus();
        bus.select = 1'b0;
        bus.read = 1'b0;
        bus.write = 1'b0;
        bus.address = 2'd0;
        bus.data_in = '0;
        bus.data_strobes = '0;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic err);
        bus.select = 1'b1;
        bus.write = 1'b1;
        bus.read = 1'b0;
        bus.address = a;
        bus.data_in = d;
        bus.data_strobes = s;
        #2 err = bus.bus_error;
        @(posedge clk);
        #1;
        idle_bus();
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        bus.select = 1'b1;
        bus.write = 1'b0;
        bus.read = 1'b1;
        bus.address = a;
        bus.data_strobes = '0;
        #2 d = bus.data_out;
        @(posedge clk);
        #1;
        idle_bus();
    endtask

    task automatic rx_send(input logic [7:0] b, input logic stop_bit, input int bitlen);
        logic [9:0] f;
        f = frame_of(b, stop_bit);
        for (int k = 0; k < 10; k++) begin
            rxd = f[k];
            cyc(bitlen);
        end
        rxd = 1'b1;
    endtask

    initial begin
        logic [31:0] d;
        logic        e;
        logic [7:0]  b, b2;
        logic [9:0]  fr;

        idle_bus();
        cyc(3);
        check("rst_txd", 32'(txd), 32'd1);
        check("rst_irq", 32'(irq), 32'd0);
        rst_n = 1'b1;
        bus_read(2'd1, d); check("rst_status", d, 32'h01);
        bus_read(2'd2, d); check("rst_divisor", d, 32'h0363);
        bus_read(2'd3, d); check("rst_control", d, 32'h0);

        // Selected but neither read nor write: data_out must stay zero.
        bus.select = 1'b1;
        bus.address = 2'd2;
        #2 check("noread_dout", bus.data_out, 32'h0);
        cyc(1);
        idle_bus();

        bus_write(2'd2, 32'hDEAD1234, 4'b0011, e); check("div_wr_err", 32'(e), 32'd0);
        bus_write(2'd2, 32'h5678AB99, 4'b0010, e);
        bus_read(2'd2, d); check("div_lane1", d, 32'h0000AB34);

        bus_write(2'd0, 32'h55, 4'b1110, e); check("data_nostrb_err", 32'(e), 32'd1);
        cyc(2);
        bus_read(2'd1, d); check("data_nostrb_status", d, 32'h01);

        // 0xA5 at 4 clocks per bit, sampled every clock.
        bus_write(2'd2, 32'd3, 4'b0011, e);
        bus_write(2'd0, 32'hA5, 4'b0001, e); check("a5_err", 32'(e), 32'd0);
        check("a5_pre_txd", 32'(txd), 32'd1);
        cyc(1);
        fr = frame_of(8'hA5, 1'b1);
        for (int i = 0; i < 40; i++) begin
            check("a5_txd", 32'(txd), 32'(fr[i / 4]));
            cyc(1);
        end
        bus_read(2'd1, d); check("a5_done_status", d, 32'h01);

        // Three random bytes back to back: one continuous bit stream, no idle gap.
        for (int k = 0; k < 3; k++) begin
            b = 8'($urandom);
            txq.push_back(b);
            bus_write(2'd0, {24'b0, b}, 4'b0001, e);
            check("rtx_err", 32'(e), 32'd0);
        end
        cyc(1);
        while (txq.size() > 0) begin
            fr = frame_of(txq.pop_front(), 1'b1);
            for (int k = 0; k < 10; k++) begin
                check("rtx_txd", 32'(txd), 32'(fr[k]));
                cyc(4);
            end
        end
        cyc(4);
        bus_read(2'd1, d); check("rtx_done_status", d, 32'h01);

        bus_write(2'd2, 32'd7, 4'b0011, e);
        rx_send(8'h3C, 1'b1, 8);
        cyc(2);
        bus_read(2'd1, d); check("rx3c_status", d, 32'h05);
        bus_read(2'd0, d); check("rx3c_data", d, 32'h3C);
        bus_read(2'd1, d); check("rx3c_cleared", d, 32'h01);

        for (int k = 0; k < 3; k++) begin
            b = 8'($urandom);
            rxq.push_back(b);
            rx_send(b, 1'b1, 8);
            cyc(2);
            bus_read(2'd0, d);
            check("rrx_data", d, {24'b0, rxq.pop_front()});
        end

        b = 8'($urandom);
        b2 = 8'($urandom);
        rx_send(b, 1'b1, 8);
        cyc(2);
        rx_send(b2, 1'b1, 8);
        cyc(2);
        bus_read(2'd1, d); check("ovr_status", d, 32'h0D);
        bus_read(2'd1, d); check("ovr_status2", d, 32'h05);
        bus_read(2'd0, d); check("ovr_data", d, {24'b0, b2});

        rxd = 1'b0;
        cyc(1);
        rxd = 1'b1;
        cyc(20);
        bus_read(2'd1, d); check("glitch_status", d, 32'h01);

        b = 8'($urandom);
        rx_send(b, 1'b0, 8);
        cyc(4);
        bus_read(2'd1, d); check("ferr_status", d, 32'h25);
        bus_read(2'd1, d); check("ferr_status2", d, 32'h05);
        bus_read(2'd0, d); check("ferr_data", d, {24'b0, b});

        bus_write(2'd3, 32'hFFFF_FFF2, 4'b0001, e);
        check("irq_t0", 32'(irq), 32'd0);
        cyc(1);
        check("irq_t1", 32'(irq), 32'd1);
        bus_read(2'd3, d); check("ctrl_read", d, 32'h2);

        // Stalled transmitter: capacity is the FIFO plus the byte already popped.
        bus_write(2'd2, 32'hFFFF, 4'b0011, e);
        for (int i = 0; i < int'(Depth) + 2; i++) begin
            bus_write(2'd0, 32'($urandom), 4'b0001, e);
            check("stall_err", 32'(e), 32'(i >= int'(Depth) + 1));
        end
        bus_read(2'd1, d); check("stall_status", d, 32'h12);
        check("stall_txd", 32'(txd), 32'd0);

        rst_n = 1'b0;
        cyc(1);
        check("midrst_txd", 32'(txd), 32'd1);
        check("midrst_irq", 32'(irq), 32'd0);
        rst_n = 1'b1;
        bus_read(2'd1, d); check("midrst_status", d, 32'h01);
        bus_read(2'd3, d); check("midrst_control", d, 32'h0);
        cyc(5);
        check("midrst_txd_idle", 32'(txd), 32'd1);
        check("midrst_irq_idle", 32'(irq), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bus_uart.md
BUS_UART -- requirements
Module: bus_uart

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, TX FIFO depth in bytes (power of two, 2..16).
REQ-002 Parameter DIVISOR_RESET, default 16'h0363, reset value of DIVISOR (clocks per bit minus one).
REQ-003 clock  input  1  sole clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset; sampled on rising edge of clock.
REQ-005 select  input  1  decoded chip select from the system address decoder.
REQ-006 address  input  [3:2]  word offset within the block.
REQ-007 data_in  input  32  write data from the initiator.
REQ-008 data_out  output  32  read data to the initiator.
REQ-009 data_strobes  input  4  byte-lane enables; bit n qualifies data_in[8n+7:8n].
REQ-010 read  input  1  read cycle qualifier.
REQ-011 write  input  1  write cycle qualifier.
REQ-012 bus_error  output  1  combinational; rejected access in the current cycle.
REQ-013 txd  output  1  serial transmit line, idle high.
REQ-014 rxd  input  1  serial receive line, asynchronous.
REQ-015 irq  output  1  registered interrupt request, active high.

Function
REQ-016 Access = select & (read | write); the block is zero-wait-state; read data SHALL be valid combinationally in the same cycle; side effects commit at the next rising edge.
REQ-017 data_out SHALL be 0 whenever there is no read access.
REQ-018 Offset 0 DATA: write with strobe[0] pushes data_in[7:0] into the TX FIFO; read returns {24'b0, rx_byte} and clears rx_valid.
REQ-019 Offset 1 STATUS (read-only): bit0 tx_empty, bit1 tx_full, bit2 rx_valid, bit3 rx_overrun, bit4 tx_busy, bit5 rx_frame_err, others 0; a read clears bits 3 and 5.
REQ-020 Offset 2 DIVISOR: bits [15:0] read/write; lanes 0/1 written independently by strobes; bits [31:16] read 0.
REQ-021 Offset 3 CONTROL: bit0 rx_ie, bit1 tx_ie, lane 0 only; others read 0.
REQ-022 bus_error SHALL assert for a DATA write while tx_full (byte dropped, no state change), or for a DATA write with strobe[0]=0.
REQ-023 Push and pop in the same cycle: pop always proceeds; push is rejected if tx_full was set at the start of the cycle.
REQ-024 TX FSM states IDLE, START, DATA, STOP; IDLE->START when FIFO is non-empty (pops one byte); each bit lasts DIVISOR+1 clocks; DATA sends 8 bits LSB first; STOP->IDLE, or STOP->START directly if the FIFO is non-empty (no idle gap).
REQ-025 tx_busy = FSM not in IDLE; txd = 1 in IDLE and STOP, 0 in START.
REQ-026 rxd SHALL pass through a two-flop synchronizer before use.
REQ-027 RX FSM states IDLE, START, DATA, STOP; a synchronized 1->0 edge enters START; the start bit is sampled at DIVISOR/2 (truncating) clocks and, if high, returns to IDLE (glitch); data and stop bits are sampled every DIVISOR+1 clocks thereafter.
REQ-028 On the stop sample: rx_byte loads; rx_valid sets; rx_frame_err sets if the stop bit is 0; rx_overrun sets if rx_valid was already 1 and not being cleared this cycle; the new byte overwrites the old one.
REQ-029 Simultaneous DATA read and RX completion: the new byte loads, rx_valid stays 1, no overrun.
REQ-030 Simultaneous STATUS read and new overrun/frame error: set wins.
REQ-031 A DIVISOR write takes effect at the next bit-counter reload; a bit in progress completes with the old count.
REQ-032 irq registered = (rx_ie & rx_valid) | (tx_ie & tx_empty), one-clock latency.

Reset
REQ-033 With reset=0 at a rising edge: TX FIFO empty, both FSMs IDLE, txd=1, irq=0, rx_valid/overrun/frame_err=0, CONTROL=0, DIVISOR=DIVISOR_RESET, synchronizer flops=1.
REQ-034 Reset mid-frame SHALL abort the frame; txd is 1 from the first edge with reset low.

Verification
REQ-035 DIVISOR=3, write DATA 0xA5 -> txd shows 0,1,0,1,0,0,1,0,1,1, 4 clocks per bit; tx_busy is 0 after the stop bit.
REQ-036 Nine DATA writes back-to-back with the transmitter stalled by DIVISOR=0xFFFF -> writes 1-8 accepted plus one extra (first pop); the next write gives bus_error=1; STATUS bit1=1.
REQ-037 DIVISOR=7, drive rxd frame 0x3C -> rx_valid=1; DATA read returns 0x0000003C; rx_valid=0 next cycle.
REQ-038 Two received frames without a read -> STATUS=0x0C (rx_valid, overrun; bits 0/4 per TX state); a second STATUS read shows bit3=0; DATA returns the second byte.
REQ-039 1-clock low glitch on rxd with DIVISOR=7 -> no rx_valid; a frame with stop bit 0 -> rx_frame_err=1.
REQ-040 CONTROL=0x2 with the FIFO empty -> irq=1 one cycle later; reset low mid-TX -> txd=1, irq=0, STATUS=0x01.
